// File: rtl/div_sequencer.sv
// Sequencer for an unsigned restoring divider that borrows the shared ALU for its subtract.
// Owns the partial remainder (R), quotient/shift register (Q) and divisor (D).
module div_sequencer #(
  parameter int         BITS     = 32,
  parameter logic [4:0] SEL_PASS = 5'b00000,
  parameter logic [4:0] SEL_SUB  = 5'b00101,
  localparam int        CW       = $clog2(BITS + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [BITS-1:0] dividend,
  input  logic [BITS-1:0] divisor,
  output logic [4:0]      alu_sel,
  output logic [BITS-1:0] alu_a,
  output logic [BITS-1:0] alu_b,
  input  logic [BITS-1:0] alu_out,
  input  logic            alu_cout,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic [BITS-1:0] quotient,
  output logic [BITS-1:0] remainder
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_SUB, S_DONE} state_t;

  state_t          r_state, w_state_next;
  logic [BITS-1:0] r_r, r_q, r_d;
  logic            r_hi;
  logic [CW-1:0]   r_count;
  logic            r_busy, r_done, r_div_zero;
  logic [BITS-1:0] r_quotient, r_remainder;

  logic            w_take;
  logic [BITS-1:0] w_r_sub, w_q_sub;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    alu_sel      = SEL_PASS;
    case (r_state)
      S_IDLE:  if (start) w_state_next = (divisor == '0) ? S_DONE : S_SHIFT;
      S_SHIFT: w_state_next = S_SUB;
      S_SUB: begin
        alu_sel      = SEL_SUB;
        w_state_next = (r_count == '0) ? S_DONE : S_SHIFT;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign alu_a = r_r;
  assign alu_b = r_d;

  // A set hi bit means the shifted remainder already exceeds D, so the wrapped difference is exact.
  assign w_take  = r_hi | alu_cout;
  assign w_r_sub = w_take ? alu_out : r_r;
  assign w_q_sub = {r_q[BITS-1:1], w_take};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_r         <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_hi        <= 1'b0;
      r_count     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_div_zero  <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      r_busy <= (w_state_next == S_SHIFT) || (w_state_next == S_SUB);
      r_done <= (w_state_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              r_r        <= '0;
              r_q        <= dividend;
              r_d        <= divisor;
              r_count    <= CW'(BITS);
              r_div_zero <= 1'b0;
            end else begin
              r_quotient  <= '1;
              r_remainder <= dividend;
              r_div_zero  <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          {r_hi, r_r, r_q} <= {r_r, r_q, 1'b0};
          r_count          <= r_count - CW'(1);
        end
        S_SUB: begin
          r_r <= w_r_sub;
          r_q <= w_q_sub;
          if (r_count == '0) begin
            r_quotient  <= w_q_sub;
            r_remainder <= w_r_sub;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign div_zero  = r_div_zero;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: behavioural ALU, arithmetic reference for
// results, per-cycle ALU-port expectations and handshake timing.
module tb_div_sequencer;
  localparam int         BITS     = 32;
  localparam logic [4:0] SEL_PASS = 5'b00000;
  localparam logic [4:0] SEL_SUB  = 5'b00101;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic [BITS-1:0] dividend = '0;
  logic [BITS-1:0] divisor = '0;
  logic [4:0]      alu_sel;
  logic [BITS-1:0] alu_a, alu_b, alu_out;
  logic            alu_cout;
  logic            busy, done, div_zero;
  logic [BITS-1:0] quotient, remainder;
  logic [BITS:0]   alu_sum;

  int n_checks = 0;
  int n_errors = 0;

  div_sequencer #(.BITS(BITS)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_cout(alu_cout),
    .busy(busy), .done(done), .div_zero(div_zero),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  // Shared ALU: transfer A, or A + ~B + 1 with carry out meaning "no borrow".
  always_comb begin
    alu_sum  = {1'b0, alu_a} + {1'b0, ~alu_b} + {{BITS{1'b0}}, 1'b1};
    alu_out  = alu_a;
    alu_cout = 1'b0;
    if (alu_sel == SEL_SUB) begin
      alu_out  = alu_sum[BITS-1:0];
      alu_cout = alu_sum[BITS];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Value on ALU A during the k-th subtract (k=1..BITS): previous partial remainder
  // doubled plus the next dividend bit, seen through a BITS-wide register.
  function automatic logic [BITS-1:0] sub_a(input logic [BITS-1:0] a, input logic [BITS-1:0] b, input int k);
    logic [63:0] prev;
    logic [63:0] t;
    prev = ({32'd0, a} >> (33 - k)) % {32'd0, b};
    t    = prev * 2 + {63'd0, a[32-k]};
    return t[BITS-1:0];
  endfunction

  // Assumes the DUT is idle and we are just past a rising edge.
  task automatic run_div(input string tag, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                         input int inj, input logic [BITS-1:0] ia, input logic [BITS-1:0] ib,
                         input bit start_in_done);
    logic [BITS-1:0] eq, er;
    int dc;
    eq = (b == 0) ? '1 : a / b;
    er = (b == 0) ? a : a % b;
    dc = (b == 0) ? 1 : 2 * BITS + 1;
    start = 1'b1; dividend = a; divisor = b;
    for (int c = 1; c <= dc; c++) begin
      @(posedge clk); #1;
      check({tag, " done"}, {63'd0, done}, {63'd0, c == dc});
      check({tag, " busy"}, {63'd0, busy}, {63'd0, (b != 0) && (c < dc)});
      if ((b != 0) && (c < dc) && (c % 2 == 0)) begin
        check({tag, " sel_sub"}, {59'd0, alu_sel}, {59'd0, SEL_SUB});
        check({tag, " alu_a"}, {32'd0, alu_a}, {32'd0, sub_a(a, b, c / 2)});
        check({tag, " alu_b"}, {32'd0, alu_b}, {32'd0, b});
      end else begin
        check({tag, " sel_pass"}, {59'd0, alu_sel}, {59'd0, SEL_PASS});
      end
      if (c == inj) begin
        start = 1'b1; dividend = ia; divisor = ib;
      end else if ((c == dc) && start_in_done) begin
        start = 1'b1; dividend = $urandom; divisor = $urandom | 32'd1;
      end else begin
        start = 1'b0; dividend = $urandom; divisor = $urandom;
      end
    end
    check({tag, " quotient"}, {32'd0, quotient}, {32'd0, eq});
    check({tag, " remainder"}, {32'd0, remainder}, {32'd0, er});
    check({tag, " div_zero"}, {63'd0, div_zero}, {63'd0, b == 0});
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " idle_busy"}, {63'd0, busy}, 64'd0);
    check({tag, " idle_done"}, {63'd0, done}, 64'd0);
    check({tag, " held_q"}, {32'd0, quotient}, {32'd0, eq});
    $display("%s: %0d / %0d -> q=%0d r=%0d dz=%0d", tag, a, b, quotient, remainder, div_zero);
  endtask

  initial begin
    int dones;
    logic [BITS-1:0] ra, rb;

    repeat (3) @(posedge clk);
    #1;
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst done", {63'd0, done}, 64'd0);
    check("rst dz", {63'd0, div_zero}, 64'd0);
    check("rst q", {32'd0, quotient}, 64'd0);
    check("rst r", {32'd0, remainder}, 64'd0);
    check("rst sel", {59'd0, alu_sel}, {59'd0, SEL_PASS});
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_div("d100_7", 32'd100, 32'd7, 0, 0, 0, 1'b0);
    run_div("dhi", 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 0, 1'b0);
    run_div("d5_10", 32'd5, 32'd10, 0, 0, 0, 1'b0);
    run_div("dmax_1", 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 1'b0);
    run_div("dzero", 32'd1234, 32'd0, 0, 0, 0, 1'b0);
    run_div("d9_3", 32'd9, 32'd3, 0, 0, 0, 1'b0);
    run_div("dinj", 32'd100, 32'd7, 10, 32'd50, 32'd5, 1'b1);

    // Reset in the middle of a divide abandons it with no done pulse.
    start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("midrst busy", {63'd0, busy}, 64'd0);
    check("midrst done", {63'd0, done}, 64'd0);
    check("midrst q", {32'd0, quotient}, 64'd0);
    check("midrst r", {32'd0, remainder}, 64'd0);
    check("midrst alu_a", {32'd0, alu_a}, 64'd0);
    check("midrst alu_b", {32'd0, alu_b}, 64'd0);
    dones = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("midrst no_done", 64'(dones), 64'd0);
    $display("midrst: divide abandoned, q=%0d r=%0d", quotient, remainder);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom >> $urandom_range(0, 31);
      rb = ($urandom_range(0, 15) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      run_div("rand", ra, rb, 0, 0, 0, (i % 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
